// File: rtl/spike_aer_encoder.sv
// Spike-to-AER encoder: captures spike pulses into pending flags and issues round-robin address events.
// Optional macro AER_TIMESTAMP_EN adds a free-running counter and the o_ev_ts event timestamp port.
module spike_aer_encoder #(
    parameter int N_CH   = 3,
    parameter int ADDR_W = 2
`ifdef AER_TIMESTAMP_EN
    ,parameter int TS_W  = 8
`endif
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [N_CH-1:0]   i_spike_in,
    input  logic              i_ev_ready,
    input  logic              i_clear_ovf,
    output logic              o_ev_valid,
    output logic [ADDR_W-1:0] o_ev_addr,
    output logic [N_CH-1:0]   o_pending,
    output logic              o_overflow
`ifdef AER_TIMESTAMP_EN
    ,output logic [TS_W-1:0]  o_ev_ts
`endif
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [N_CH-1:0]   r_pending;
    logic [ADDR_W-1:0] r_ev_addr;
    logic [ADDR_W-1:0] r_rr;
    logic              r_overflow;

    logic              w_advance;
    logic              w_load;
    logic              w_found;
    logic              w_drop;
    logic [ADDR_W-1:0] w_grant;
    logic [N_CH-1:0]   w_grant_vec;
    logic [N_CH-1:0]   w_take;
    logic [ADDR_W:0]   w_idx;

    // Round-robin search starting one past the last grant; the index wraps at N_CH, not at 2**ADDR_W.
    always_comb begin
        w_found     = 1'b0;
        w_grant     = '0;
        w_grant_vec = '0;
        w_idx       = '0;
        for (int k = 1; k <= N_CH; k++) begin
            w_idx = {1'b0, r_rr} + (ADDR_W+1)'(k);
            if (w_idx >= (ADDR_W+1)'(N_CH))
                w_idx = w_idx - (ADDR_W+1)'(N_CH);
            for (int j = 0; j < N_CH; j++) begin
                if (!w_found && r_pending[j] && (w_idx == (ADDR_W+1)'(j))) begin
                    w_found        = 1'b1;
                    w_grant        = ADDR_W'(j);
                    w_grant_vec[j] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_advance    = (r_state == S_IDLE) || i_ev_ready;
        w_load       = w_advance && w_found;
        w_take       = w_load ? w_grant_vec : '0;
        w_drop       = |(i_spike_in & r_pending & ~w_take);
        w_state_next = r_state;
        if (w_advance)
            w_state_next = w_load ? S_HOLD : S_IDLE;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_pending  <= '0;
            r_ev_addr  <= '0;
            r_rr       <= ADDR_W'(N_CH - 1);
            r_overflow <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            // A fresh spike always re-arms its flag, even on the edge that grants it.
            r_pending <= i_spike_in | (r_pending & ~w_take);
            if (w_load) begin
                r_ev_addr <= w_grant;
                r_rr      <= w_grant;
            end
            if (w_drop)
                r_overflow <= 1'b1;
            else if (i_clear_ovf)
                r_overflow <= 1'b0;
        end
    end

`ifdef AER_TIMESTAMP_EN
    logic [TS_W-1:0] r_ts_cnt;
    logic [TS_W-1:0] r_ev_ts;

    // The event captures the counter value before this edge's increment.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_ts_cnt <= '0;
            r_ev_ts  <= '0;
        end else begin
            r_ts_cnt <= r_ts_cnt + 1'b1;
            if (w_load)
                r_ev_ts <= r_ts_cnt;
        end
    end

    assign o_ev_ts = r_ev_ts;
`endif

    assign o_ev_valid = (r_state == S_HOLD);
    assign o_ev_addr  = r_ev_addr;
    assign o_pending  = r_pending;
    assign o_overflow = r_overflow;

endmodule

// File: tb/tb_spike_aer_encoder.sv
// Randomised self-checking bench for spike_aer_encoder against an event-level reference model.
// Honours AER_TIMESTAMP_EN the same way as the design.
module tb_spike_aer_encoder;

    localparam int N_CH   = 3;
    localparam int ADDR_W = 2;
    localparam int TS_W   = 8;

    logic              clk;
    logic              reset;
    logic [N_CH-1:0]   spikeIn;
    logic              evReady;
    logic              clearOvf;
    logic              evValid;
    logic [ADDR_W-1:0] evAddr;
    logic [N_CH-1:0]   pendingOut;
    logic              overflowOut;
`ifdef AER_TIMESTAMP_EN
    logic [TS_W-1:0]   evTs;
`endif

    int totalChecks = 0;
    int badChecks   = 0;

    // Reference model state
    bit mPend[N_CH];
    bit mValid;
    int mAddr;
    int mRr;
    bit mOvf;
    int mCnt;
    int mTs;

    spike_aer_encoder #(
        .N_CH   (N_CH),
        .ADDR_W (ADDR_W)
`ifdef AER_TIMESTAMP_EN
        ,.TS_W  (TS_W)
`endif
    ) dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_spike_in  (spikeIn),
        .i_ev_ready  (evReady),
        .i_clear_ovf (clearOvf),
        .o_ev_valid  (evValid),
        .o_ev_addr   (evAddr),
        .o_pending   (pendingOut),
        .o_overflow  (overflowOut)
`ifdef AER_TIMESTAMP_EN
        ,.o_ev_ts    (evTs)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        totalChecks++;
        if (observed !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < N_CH; i++) mPend[i] = 1'b0;
        mValid = 1'b0;
        mAddr  = 0;
        mRr    = N_CH - 1;
        mOvf   = 1'b0;
        mCnt   = 0;
        mTs    = 0;
    endtask

    // One clock edge of the event-level behaviour.
    task automatic modelStep(input logic [N_CH-1:0] spk, input bit rdy, input bit clr);
        bit advance;
        bit anyPend;
        bit drop;
        bit s;
        int grant;
        anyPend = 1'b0;
        for (int i = 0; i < N_CH; i++) anyPend |= mPend[i];
        advance = !mValid || rdy;
        grant = -1;
        if (advance && anyPend) begin
            for (int k = 1; k <= N_CH; k++) begin
                int c;
                c = (mRr + k) % N_CH;
                if (mPend[c]) begin
                    grant = c;
                    break;
                end
            end
        end
        drop = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            s = bit'(spk >> i);
            if (s && mPend[i] && (i != grant)) drop = 1'b1;
            if (s) mPend[i] = 1'b1;
            else if (i == grant) mPend[i] = 1'b0;
        end
        if (drop) mOvf = 1'b1;
        else if (clr) mOvf = 1'b0;
        if (grant >= 0) begin
            mValid = 1'b1;
            mAddr  = grant;
            mRr    = grant;
            mTs    = mCnt;
        end else if (advance) begin
            mValid = 1'b0;
        end
        mCnt = (mCnt + 1) % (1 << TS_W);
    endtask

    function automatic logic [31:0] packedPend();
        logic [31:0] p;
        p = '0;
        for (int i = 0; i < N_CH; i++)
            if (mPend[i]) p = p | (32'd1 << i);
        return p;
    endfunction

    task automatic compareAll(input string phase);
        checkOutput({phase, ".valid"}, 32'(evValid), 32'(mValid));
        checkOutput({phase, ".addr"}, 32'(evAddr), 32'(mAddr));
        checkOutput({phase, ".pending"}, 32'(pendingOut), packedPend());
        checkOutput({phase, ".overflow"}, 32'(overflowOut), 32'(mOvf));
`ifdef AER_TIMESTAMP_EN
        checkOutput({phase, ".ts"}, 32'(evTs), 32'(mTs));
`endif
    endtask

    // Drive inputs between edges, advance one edge, then compare just after it.
    task automatic applyStimulus(input string phase, input logic [N_CH-1:0] spk, input bit rdy, input bit clr);
        spikeIn  = spk;
        evReady  = rdy;
        clearOvf = clr;
        @(posedge clk);
        modelStep(spk, rdy, clr);
        #1;
        compareAll(phase);
    endtask

    // Reset is raised and dropped between two edges; outputs must clear without waiting for a clock.
    task automatic midReset();
        reset = 1'b1;
        #2;
        checkOutput("async.valid", 32'(evValid), 32'd0);
        checkOutput("async.pending", 32'(pendingOut), 32'd0);
        checkOutput("async.overflow", 32'(overflowOut), 32'd0);
        checkOutput("async.addr", 32'(evAddr), 32'd0);
        reset = 1'b0;
        modelReset();
    endtask

    initial begin
        reset    = 1'b1;
        spikeIn  = '0;
        evReady  = 1'b0;
        clearOvf = 1'b0;
        modelReset();
        #3;
        compareAll("reset");
        reset = 1'b0;

        // Single spike, then a full burst with the sink always ready
        applyStimulus("single", 3'b001, 1'b1, 1'b0);
        for (int c = 0; c < 3; c++) applyStimulus("single", 3'b000, 1'b1, 1'b0);
        applyStimulus("burst", 3'b111, 1'b1, 1'b0);
        for (int c = 0; c < 5; c++) applyStimulus("burst", 3'b000, 1'b1, 1'b0);

        // Backpressure: repeated ch1 spikes while the sink stalls, then drain and clear
        for (int c = 0; c < 7; c++)
            applyStimulus("stall", ((c == 0) || (c == 3) || (c == 5)) ? 3'b010 : 3'b000, 1'b0, 1'b0);
        for (int c = 0; c < 4; c++) applyStimulus("drain", 3'b000, 1'b1, 1'b0);
        applyStimulus("clear", 3'b000, 1'b1, 1'b1);
        applyStimulus("clear", 3'b000, 1'b1, 1'b0);

        // Two channels spiking every cycle
        for (int c = 0; c < 12; c++) applyStimulus("fair", 3'b101, 1'b1, 1'b0);
        for (int c = 0; c < 4; c++) applyStimulus("fair", 3'b000, 1'b1, 1'b0);

        // Reset while an event is held and other spikes are pending
        applyStimulus("hold", 3'b100, 1'b0, 1'b0);
        applyStimulus("hold", 3'b011, 1'b0, 1'b0);
        applyStimulus("hold", 3'b000, 1'b0, 1'b0);
        midReset();
        applyStimulus("postrst", 3'b111, 1'b1, 1'b0);
        for (int c = 0; c < 4; c++) applyStimulus("postrst", 3'b000, 1'b1, 1'b0);

        // Random traffic, long enough to wrap the timestamp counter several times
        for (int c = 0; c < 900; c++) begin
            logic [N_CH-1:0] spk;
            spk = N_CH'($urandom) & N_CH'($urandom);
            applyStimulus("rand", spk, ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));
            if ((c % 300) == 150) midReset();
        end

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
